seq_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider, the inverse of the multiply datapath.

---
 rtl/seq_divider.sv | 137 +++++++++++++
 tb/tb_seq_divider.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size-1:0] quotient,
  output logic [size-1:0] remainder,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            zero
);

  localparam int CW = $clog2(size + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] b_q, b_d;
  logic [size-1:0] q_q, q_d;
  logic [size:0]   r_q, r_d;
  logic [size-1:0] quot_q, quot_d;
  logic [size-1:0] rem_q, rem_d;
  logic            err_q, err_d;
  logic            zero_q, zero_d;

  logic            accept;
  logic            last_iter;
  logic [size:0]   r_sh;
  logic [size+1:0] diff;
  logic            neg;
  logic [size:0]   r_next;
  logic [size-1:0] q_next;

  assign accept    = start && (state_q != S_DIV);
  assign last_iter = (cnt_q == CW'(1));

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep it if non-negative.
  always_comb begin
    r_sh   = {r_q[size-1:0], q_q[size-1]};
    diff   = {1'b0, r_sh} - {2'b00, b_q};
    neg    = diff[size+1];
    r_next = neg ? r_sh : diff[size:0];
    q_next = {q_q[size-2:0], ~neg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DIV: begin
        if (last_iter) state_d = S_DONE;
      end
      default: begin
        if (accept) state_d = (b != '0) ? S_DIV : S_DONE;
        else        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers; results only move at completion or on a divide-by-zero accept.
  always_comb begin
    cnt_d  = cnt_q;
    b_d    = b_q;
    q_d    = q_q;
    r_d    = r_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    err_d  = err_q;
    zero_d = zero_q;
    if (state_q == S_DIV) begin
      r_d   = r_next;
      q_d   = q_next;
      cnt_d = cnt_q - CW'(1);
      if (last_iter) begin
        quot_d = q_next;
        rem_d  = r_next[size-1:0];
        err_d  = 1'b0;
        zero_d = (q_next == '0);
      end
    end else if (accept) begin
      if (b != '0) begin
        b_d   = b;
        q_d   = a;
        r_d   = '0;
        cnt_d = CW'(size);
      end else begin
        quot_d = '0;
        rem_d  = '0;
        err_d  = 1'b1;
        zero_d = 1'b0;
      end
    end
  end

  always_comb begin
    busy      = (state_q == S_DIV);
    done      = (state_q == S_DONE);
    quotient  = quot_q;
    remainder = rem_q;
    err       = err_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and randomized checks of seq_divider against an arithmetic model
module tb_seq_divider;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic            busy;
  logic            done;
  logic            err;
  logic            zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.size(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int x, input int y, output int eq, output int er,
                       output int ee, output int ez);
    if (y == 0) begin
      eq = 0; er = 0; ee = 1; ez = 0;
    end else begin
      eq = x / y; er = x % y; ee = 0; ez = (eq == 0) ? 1 : 0;
    end
  endtask

  task automatic chk_results(input string tag, input int eq, input int er, input int ee, input int ez);
    chk({tag, "_q"}, 32'(quotient), eq);
    chk({tag, "_r"}, 32'(remainder), er);
    chk({tag, "_err"}, 32'(err), ee);
    chk({tag, "_zero"}, 32'(zero), ez);
  endtask

  task automatic run_op(input int ta, input int tbv, input string tag);
    int eq, er, ee, ez, lat, bcnt;
    model(ta, tbv, eq, er, ee, ez);
    @(negedge clk);
    start = 1'b1; a = SIZE'(ta); b = SIZE'(tbv);
    @(negedge clk);
    start = 1'b0; a = SIZE'($urandom); b = SIZE'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, (ee != 0) ? 1 : SIZE + 1);
    chk({tag, "_busy_cycles"}, bcnt, (ee != 0) ? 0 : SIZE);
    chk_results(tag, eq, er, ee, ez);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 0);
    chk_results({tag, "_hold"}, eq, er, ee, ez);
  endtask

  initial begin
    int eq, er, ee, ez, lat, wait_cnt, issued, dones, cyc, ca, cb, sel;
    bit outstanding, exp_done, exp_busy;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(quotient), 0);
    chk("reset_r", 32'(remainder), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_zero", 32'(zero), 0);
    rst = 1'b0;

    run_op(100, 7, "t1");
    run_op(5, 0, "t2");
    run_op(3, 9, "t3a");
    run_op(255, 1, "t3b");

    // start pulsed again mid-operation must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'd200; b = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd9;
    chk("t4_busy_mid", 32'(busy), 1);
    chk("t4_q_held_mid", 32'(quotient), 255);
    chk("t4_r_held_mid", 32'(remainder), 0);
    @(negedge clk);
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", lat, SIZE + 1);
    chk_results("t4", 66, 2, 0, 0);
    @(negedge clk);
    chk("t4_no_second_done", 32'(done), 0);

    // asynchronous reset in the middle of an operation
    start = 1'b1; a = 8'd250; b = 8'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_q", 32'(quotient), 0);
    chk("t5_rst_r", 32'(remainder), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    chk("t5_rst_err", 32'(err), 0);
    chk("t5_rst_zero", 32'(zero), 0);
    repeat (SIZE) begin
      @(negedge clk);
      chk("t5_no_done_in_rst", 32'(done), 0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_done_after_rst", 32'(done), 0);
    end
    run_op(250, 6, "t5");

    // random back-to-back ops with start held high; timing predicted from the op count alone
    outstanding = 0; wait_cnt = 0; issued = 0; dones = 0; cyc = 0;
    eq = 0; er = 0; ee = 0; ez = 0; ca = 0; cb = 0;
    while (cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (outstanding) wait_cnt--;
      exp_done = outstanding && (wait_cnt == 0);
      exp_busy = outstanding && (wait_cnt != 0);
      chk("rnd_done", 32'(done), 32'(exp_done));
      chk("rnd_busy", 32'(busy), 32'(exp_busy));
      if (exp_done) begin
        chk_results("rnd", eq, er, ee, ez);
        if (ee == 0) begin
          chk("rnd_recon", 32'(quotient) * 32'(cb) + 32'(remainder), 32'(ca));
          chk("rnd_r_lt_b", 32'(remainder < SIZE'(cb)), 1);
        end
        outstanding = 0;
        dones++;
      end
      if (!outstanding && issued < 1000) begin
        sel = $urandom_range(0, 9);
        ca = $urandom_range(0, 255);
        cb = $urandom_range(0, 255);
        case (sel)
          0: cb = 0;
          1: begin cb = $urandom_range(1, 255); ca = $urandom_range(0, cb - 1); end
          2: begin cb = $urandom_range(1, 255); ca = cb; end
          3: ca = 255;
          4: cb = 255;
          5: cb = 1;
          default: ;
        endcase
        model(ca, cb, eq, er, ee, ez);
        start = 1'b1; a = SIZE'(ca); b = SIZE'(cb);
        outstanding = 1;
        wait_cnt = (cb == 0) ? 1 : SIZE + 1;
        issued++;
      end else if (outstanding) begin
        a = SIZE'($urandom); b = SIZE'($urandom);
      end else begin
        start = 1'b0;
        break;
      end
    end
    start = 1'b0;
    chk("rnd_issued", issued, 1000);
    chk("rnd_done_count", dones, issued);
    @(negedge clk);
    chk("rnd_final_idle_done", 32'(done), 0);
    chk("rnd_final_idle_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
